// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO around a 1-cycle-latency dual-port RAM with a 2-entry output skid.
// Define RAM_FIFO_FLUSH_EN to add the synchronous i_flush input.
module ram_fifo_ctrl #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 32,
    parameter int ADDRESS = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_data,
    output logic               o_ready,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    input  logic               i_ready,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic               i_flush,
`endif
    output logic               o_ram_wr_en,
    output logic               o_ram_cs,
    output logic               o_ram_valid,
    output logic [ADDRESS-1:0] o_ram_wr_addr,
    output logic [WIDTH-1:0]   o_ram_wr_data,
    output logic               o_ram_rd_en,
    output logic [ADDRESS-1:0] o_ram_rd_addr,
    input  logic [WIDTH-1:0]   i_ram_rd_data,
    output logic [ADDRESS+1:0] o_count,
    output logic               o_empty,
    output logic               o_full
);
    localparam logic [ADDRESS:0] DEPTH_C = (ADDRESS+1)'(DEPTH);

    logic [ADDRESS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_cnt;
    logic             pend_q, pend_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             flush, push, pop, issue;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign ram_cnt       = wr_ptr_q - rd_ptr_q;
    assign o_ready       = (ram_cnt < DEPTH_C) & !flush;
    assign push          = i_valid & o_ready;
    assign o_valid       = occ_q != 2'd0;
    assign pop           = o_valid & i_ready;
    // Reads are only issued when the skid is guaranteed room once the data returns.
    assign issue         = (ram_cnt != '0) & !flush &
                           (({1'b0, occ_q} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop}));
    assign o_data        = head_q;
    assign o_ram_wr_en   = push;
    assign o_ram_cs      = push;
    assign o_ram_valid   = push;
    assign o_ram_wr_addr = wr_ptr_q[ADDRESS-1:0];
    assign o_ram_wr_data = i_data;
    assign o_ram_rd_en   = issue;
    assign o_ram_rd_addr = rd_ptr_q[ADDRESS-1:0];
    assign o_count       = {1'b0, ram_cnt} + {{(ADDRESS+1){1'b0}}, pend_q} + {{ADDRESS{1'b0}}, occ_q};
    assign o_empty       = o_count == '0;
    assign o_full        = !o_ready;

    // Next state: pointers advance on push/issue, returning data lands in head or tail of the skid.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDRESS{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{ADDRESS{1'b0}}, issue};
        pend_d   = issue;
        occ_d    = occ_q + {1'b0, pend_q} - {1'b0, pop};
        head_d   = (pend_q & ((occ_q == 2'd0) | (pop & (occ_q == 2'd1)))) ? i_ram_rd_data :
                   (pop & (occ_q == 2'd2)) ? tail_q : head_q;
        tail_d   = (pend_q & ((occ_q - {1'b0, pop}) == 2'd1)) ? i_ram_rd_data : tail_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pend_d   = 1'b0;
            occ_d    = 2'd0;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= 1'b0;
            occ_q    <= 2'd0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pend_q   <= pend_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end
endmodule
